// File: rtl/snake_pkg.sv
// Shared constants for the snake display path: tile codes, colours, grid defaults and the
// reciprocal helper used for division-free tile coordinate mapping.
package snake_pkg;

    localparam int unsigned DefTilePx = 20;
    localparam int unsigned DefGridW  = 32;
    localparam int unsigned DefGridH  = 24;

    typedef enum logic [1:0] {
        TileEmpty = 2'd0,
        TileBody  = 2'd1,
        TileHead  = 2'd2,
        TileFood  = 2'd3
    } tile_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } map_state_e;

    localparam logic [11:0] ColBlack = 12'h000;
    localparam logic [11:0] ColWall  = 12'h888;
    localparam logic [11:0] ColBody  = 12'h0F0;
    localparam logic [11:0] ColHead  = 12'h0FF;
    localparam logic [11:0] ColFood  = 12'h00F;

    // Fixed-point scale for the reciprocal; keeps floor(x/px) exact for x < 1024, px < 1000.
    localparam int unsigned RecipShift = 20;

    function automatic int unsigned recip(input int unsigned px);
        return ((32'd1 << RecipShift) + px - 1) / px;
    endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Tile map storage: 2-bit entries, one synchronous write port, one asynchronous read port.
// Contents are not reset; the renderer's clear sweep initialises them.
module tile_map_ram #(
    parameter int unsigned Depth = 768,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [1:0]       wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [1:0]       rdata
);

    logic [1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < Depth)) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses past the map (off-screen pixel positions) read as empty.
    assign rdata = (32'(raddr) < Depth) ? mem[raddr] : 2'b00;

endmodule

// File: rtl/tile_renderer.sv
// Tile-map renderer: maps pixel (row, col) to a tile colour with one cycle of latency and
// owns the map clear sweep. Define FOOD_BLINK_EN to make food tiles blink every 16 frames.
module tile_renderer
    import snake_pkg::*;
#(
    parameter int unsigned TILE_PX = DefTilePx,
    parameter int unsigned GRID_W  = DefGridW,
    parameter int unsigned GRID_H  = DefGridH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        rdn,
    output logic [11:0] Din,
    input  logic        wr_en,
    input  logic [4:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [1:0]  wr_tile,
    input  logic        clr,
    output logic        busy
);

    localparam int unsigned XW      = $clog2(GRID_W);
    localparam int unsigned YW      = $clog2(GRID_H);
    localparam int unsigned AW      = XW + YW;
    localparam int unsigned Depth   = GRID_W * GRID_H;
    localparam int unsigned Recip   = recip(TILE_PX);
    localparam logic [AW-1:0] LastIdx = AW'(Depth - 1);

    // Tile coordinates via multiply-by-reciprocal instead of a divider.
    logic [31:0] col_prod, row_prod, tx_full, ty_full;
    logic        wall;
    logic [AW-1:0] rd_addr;
    logic [1:0]  rd_data;

    assign col_prod = 32'(col) * Recip;
    assign row_prod = 32'(row) * Recip;
    assign tx_full  = col_prod >> RecipShift;
    assign ty_full  = row_prod >> RecipShift;
    assign rd_addr  = {ty_full[YW-1:0], tx_full[XW-1:0]};
    assign wall     = (tx_full == 32'd0) || (tx_full == GRID_W - 1) ||
                      (ty_full == 32'd0) || (ty_full == GRID_H - 1);

    // Clear sweep FSM.
    map_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            StClear: begin
                if (clr) begin
                    idx_d = '0;
                end else if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        endcase
    end

    assign busy = (state_q == StClear);

    // Map write port: the sweep owns it while busy, external writes are dropped.
    logic          wr_ok, ram_we;
    logic [AW-1:0] ram_waddr;
    logic [1:0]    ram_wdata;

    assign wr_ok     = !busy && wr_en && (32'(wr_x) < GRID_W) && (32'(wr_y) < GRID_H);
    assign ram_we    = busy || wr_ok;
    assign ram_waddr = busy ? idx_q : {wr_y[YW-1:0], wr_x[XW-1:0]};
    assign ram_wdata = busy ? TileEmpty : wr_tile;

    tile_map_ram #(
        .Depth (Depth),
        .AddrW (AW)
    ) u_map (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

`ifdef FOOD_BLINK_EN
    logic       frame_tick;
    logic [7:0] frame_q;

    assign frame_tick = !rdn && (32'(row) == GRID_H * TILE_PX - 1) &&
                        (32'(col) == GRID_W * TILE_PX - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 8'd0;
        end else if (frame_tick) begin
            frame_q <= frame_q + 8'd1;
        end
    end
`endif

    logic [11:0] pix_colour;

    always_comb begin
        pix_colour = ColBlack;
        if (wall) begin
            pix_colour = ColWall;
        end else begin
            unique case (tile_e'(rd_data))
                TileEmpty: pix_colour = ColBlack;
                TileBody:  pix_colour = ColBody;
                TileHead:  pix_colour = ColHead;
                TileFood: begin
`ifdef FOOD_BLINK_EN
                    pix_colour = frame_q[4] ? ColBlack : ColFood;
`else
                    pix_colour = ColFood;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Din <= ColBlack;
        end else begin
            Din <= rdn ? ColBlack : pix_colour;
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// Self-checking bench for tile_renderer: vector table of writes/pixels with a queued
// scoreboard, plus sweep, busy-drop, restart and reset-abort sequences.
module tb_tile_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        rdn;
    logic [11:0] din;
    logic        wr_en;
    logic [4:0]  wr_x, wr_y;
    logic [1:0]  wr_tile;
    logic        clr;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int unsigned cyc_cnt = 0;

    typedef struct {
        logic [11:0] exp;
        int          tag;
        int unsigned cyc;
    } sb_t;

    sb_t sb[$];

    typedef struct {
        logic        do_wr;
        logic [4:0]  wx;
        logic [4:0]  wy;
        logic [1:0]  wt;
        logic [8:0]  r;
        logic [9:0]  c;
        logic        rd;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [18];

    tile_renderer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .row     (row),
        .col     (col),
        .rdn     (rdn),
        .Din     (din),
        .wr_en   (wr_en),
        .wr_x    (wr_x),
        .wr_y    (wr_y),
        .wr_tile (wr_tile),
        .clr     (clr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: an entry pushed before a posedge is compared just after it.
    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
            #1;
            while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
                sb_t e;
                e = sb.pop_front();
                checks++;
                if (din !== e.exp) begin
                    errors++;
                    $display("FAIL px%0d: Din=%03h expected %03h", e.tag, din, e.exp);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic px(input logic [8:0] r, input logic [9:0] c, input logic rd,
                      input logic [11:0] e, input int tag);
        @(negedge clk);
        row = r;
        col = c;
        rdn = rd;
        sb.push_back('{exp: e, tag: tag, cyc: cyc_cnt});
    endtask

    task automatic write_tile(input logic [4:0] x, input logic [4:0] y, input logic [1:0] t);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_x    = x;
        wr_y    = y;
        wr_tile = t;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Called on a negedge; counts negedges (this one included) that see busy high.
    task automatic count_busy(input string name, input int exp_n);
        int n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp_n);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd100, 10'd100, 1'b0, 12'h000};
        tbl[1]  = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd0,   10'd300, 1'b0, 12'h888};
        tbl[2]  = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd479, 10'd639, 1'b0, 12'h888};
        tbl[3]  = '{1'b1, 5'd5,  5'd7,  2'd2, 9'd140, 10'd100, 1'b0, 12'h0FF};
        tbl[4]  = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd159, 10'd119, 1'b0, 12'h0FF};
        tbl[5]  = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd139, 10'd100, 1'b0, 12'h000};
        tbl[6]  = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd140, 10'd120, 1'b0, 12'h000};
        tbl[7]  = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd160, 10'd119, 1'b0, 12'h000};
        tbl[8]  = '{1'b1, 5'd0,  5'd0,  2'd3, 9'd0,   10'd0,   1'b0, 12'h888};
        tbl[9]  = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd479, 10'd639, 1'b0, 12'h888};
        tbl[10] = '{1'b1, 5'd10, 5'd10, 2'd3, 9'd200, 10'd200, 1'b0, 12'h00F};
        tbl[11] = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd219, 10'd219, 1'b1, 12'h000};
        tbl[12] = '{1'b1, 5'd2,  5'd2,  2'd1, 9'd45,  10'd59,  1'b0, 12'h0F0};
        tbl[13] = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd20,  10'd19,  1'b0, 12'h888};
        tbl[14] = '{1'b1, 5'd1,  5'd1,  2'd1, 9'd20,  10'd20,  1'b0, 12'h0F0};
        tbl[15] = '{1'b1, 5'd30, 5'd22, 2'd2, 9'd459, 10'd619, 1'b0, 12'h0FF};
        tbl[16] = '{1'b0, 5'd0,  5'd0,  2'd0, 9'd460, 10'd619, 1'b0, 12'h888};
        tbl[17] = '{1'b1, 5'd4,  5'd25, 2'd1, 9'd100, 10'd80,  1'b0, 12'h000};

        rst_n = 1'b0;
        row = '0; col = '0; rdn = 1'b1;
        wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_tile = '0; clr = 1'b0;

        // Reset state and initial sweep.
        repeat (3) @(negedge clk);
        check("rst_din", int'(din), 0);
        check("rst_busy", int'(busy), 1);
        rst_n = 1'b1;
        count_busy("reset_sweep_len", 768);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].do_wr) write_tile(tbl[i].wx, tbl[i].wy, tbl[i].wt);
            px(tbl[i].r, tbl[i].c, tbl[i].rd, tbl[i].exp, i);
        end
        @(negedge clk);
        rdn = 1'b1;
        drain();

        // Write during the last sweep cycle must be dropped.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (767) @(negedge clk);
        check("busy_last_cycle", int'(busy), 1);
        wr_en = 1'b1; wr_x = 5'd3; wr_y = 5'd3; wr_tile = 2'd1;
        @(negedge clk);
        wr_en = 1'b0;
        check("busy_after_sweep", int'(busy), 0);
        px(9'd70, 10'd70, 1'b0, 12'h000, 100);
        px(9'd150, 10'd110, 1'b0, 12'h000, 101);
        px(9'd45, 10'd59, 1'b0, 12'h000, 102);
        @(negedge clk);
        rdn = 1'b1;
        drain();

        // clr during a sweep restarts it.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (100) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        count_busy("restart_sweep_len", 768);

        // Reset mid-sweep aborts and restarts the sweep from index 0.
        write_tile(5'd6, 5'd6, 2'd2);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 1);
        check("midrst_din", int'(din), 0);
        rst_n = 1'b1;
        count_busy("midrst_sweep_len", 768);
        px(9'd130, 10'd130, 1'b0, 12'h000, 103);
        @(negedge clk);
        rdn = 1'b1;
        drain();

`ifdef FOOD_BLINK_EN
        write_tile(5'd10, 5'd10, 2'd3);
        px(9'd200, 10'd200, 1'b0, 12'h00F, 200);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            row = 9'd479; col = 10'd639; rdn = 1'b0;
            repeat (16) @(negedge clk);
            rdn = 1'b1;
            px(9'd200, 10'd200, 1'b0, (k == 0) ? 12'h000 : 12'h00F, 201 + k);
            @(negedge clk);
            rdn = 1'b1;
            drain();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
